mdu: RTL and testbench

Multi-cycle RISC-V M-extension unit (multiply/divide/remainder) beside the single-cycle execute datapath. It accepts an operation with a valid/ready handshake, iterates one bit per cycle, and returns the XLEN-bit result through a second valid/ready handshake. The unit is parametrised in data width. It supports the 32-bit word variants (MULW/DIVW/DIVUW/REMW/REMUW), which the single-cycle datapath does not.

---
 rtl/mdu.sv | 154 +++++++++++++++
 tb/tb_mdu.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multi-cycle RISC-V M-extension unit: shift-add multiply and restoring
// divide, one bit per cycle, with valid/ready handshakes on both sides.
module mdu #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic            word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_n;

    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic              word_q;
    logic              neg_q;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplr;

    logic            accept, special, last;
    logic            zext, s1_signed, s2_signed;
    logic            sign1, sign2, div0, ovf;
    logic [2:0]      f_eff;
    logic [XLEN-1:0] a, b, mag1, mag2, min_val;
    logic [XLEN-1:0] spec_raw, spec_fin;
    logic [CW-1:0]   n_steps;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready && !flush;
    assign n_steps   = word_q ? CW'(32) : CW'(XLEN);
    assign last      = (cnt == n_steps);

    // Operand conditioning at accept
    always_comb begin
        f_eff = (word && !funct3[2]) ? 3'b000 : funct3;
        zext  = f_eff[2] & f_eff[0];
        a     = src1;
        b     = src2;
        if (word) begin
            a = zext ? XLEN'(src1[31:0]) : XLEN'($signed(src1[31:0]));
            b = zext ? XLEN'(src2[31:0]) : XLEN'($signed(src2[31:0]));
        end
        s1_signed = f_eff inside {3'b001, 3'b010, 3'b100, 3'b110};
        s2_signed = f_eff inside {3'b001, 3'b100, 3'b110};
        sign1 = s1_signed & a[XLEN-1];
        sign2 = s2_signed & b[XLEN-1];
        mag1  = sign1 ? -a : a;
        mag2  = sign2 ? -b : b;
        min_val = word ? XLEN'($signed(32'h8000_0000))
                       : {1'b1, {(XLEN-1){1'b0}}};
        div0 = f_eff[2] && (b == '0);
        ovf  = f_eff[2] && !f_eff[0] && (a == min_val) && (b == '1);
        special = div0 || ovf;
        if (div0)
            spec_raw = f_eff[1] ? a : '1;
        else
            spec_raw = f_eff[1] ? '0 : a;
        spec_fin = word ? XLEN'($signed(spec_raw[31:0])) : spec_raw;
    end

    logic [XLEN:0]     div_rs, div_diff;
    logic              q_bit;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res, quot, remv, raw, fin;

    // Divide step and final result shaping
    always_comb begin
        div_rs   = {acc[XLEN-1:0], mplr[XLEN-1]};
        div_diff = div_rs - {1'b0, mcand[XLEN-1:0]};
        q_bit    = !div_diff[XLEN];
        prod     = neg_q ? -acc : acc;
        mul_res  = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0]
                                        : prod[2*XLEN-1:XLEN];
        quot     = neg_q ? -mplr : mplr;
        remv     = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        raw      = op_q[2] ? (op_q[1] ? remv : quot) : mul_res;
        fin      = word_q ? XLEN'($signed(raw[31:0])) : raw;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (accept) state_n = special ? DONE : CALC;
            CALC: if (last) state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            op_q   <= '0;
            word_q <= 1'b0;
            neg_q  <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplr   <= '0;
            result <= '0;
        end else if (accept) begin
            cnt    <= '0;
            op_q   <= f_eff;
            word_q <= word;
            neg_q  <= (f_eff[2] & f_eff[1]) ? sign1 : (sign1 ^ sign2);
            acc    <= '0;
            if (f_eff[2]) begin
                mcand <= {{XLEN{1'b0}}, mag2};
                // Word dividend is left-aligned so 32 steps consume it
                mplr  <= word ? (mag1 << (XLEN - 32)) : mag1;
            end else begin
                mcand <= {{XLEN{1'b0}}, mag1};
                mplr  <= mag2;
            end
            if (special) result <= spec_fin;
        end else if (state == CALC && !flush) begin
            if (last) begin
                result <= fin;
            end else begin
                cnt <= cnt + 1'b1;
                if (!op_q[2]) begin
                    if (mplr[0]) acc <= acc + mcand;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                end else begin
                    acc  <= {{XLEN{1'b0}},
                             q_bit ? div_diff[XLEN-1:0] : div_rs[XLEN-1:0]};
                    mplr <= {mplr[XLEN-2:0], q_bit};
                end
            end
        end
    end
endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: arithmetic, special cases, word ops,
// backpressure, flush and asynchronous reset.
module tb_mdu;
    localparam int XLEN = 64;

    localparam logic [2:0] F_MUL   = 3'b000;
    localparam logic [2:0] F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV   = 3'b100;
    localparam logic [2:0] F_DIVU  = 3'b101;
    localparam logic [2:0] F_REM   = 3'b110;
    localparam logic [2:0] F_REMU  = 3'b111;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      funct3 = '0;
    logic            word = 1'b0;
    logic [XLEN-1:0] src1 = '0;
    logic [XLEN-1:0] src2 = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] result;
    logic            busy;

    int checks = 0;
    int errors = 0;

    mdu #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .word(word),
        .src1(src1), .src2(src2),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic w,
                         input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        funct3   = f;
        word     = w;
        src1     = a;
        src2     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int exp_lat);
        int lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 200);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        if (exp_lat > 0) check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("take_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic op(input string tag, input logic [2:0] f,
                      input logic w, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] exp,
                      input int lat);
        issue(f, w, a, b);
        wait_out(tag, lat);
        check(tag, result, exp);
        take();
    endtask

    initial begin
        logic seen;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        op("mul", F_MUL, 0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB,
           64'hFFFF_FFFF_FFFF_FFF1, 65);
        op("mulhu", F_MULHU, 0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        op("div", F_DIV, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        op("rem", F_REM, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        op("divu", F_DIVU, 0, 64'd100, 64'd7, 64'd14, 65);
        op("remu", F_REMU, 0, 64'd100, 64'd7, 64'd2, 65);

        op("divu0", F_DIVU, 0, 64'd5, 64'd0, '1, 1);
        op("rem0", F_REM, 0, 64'd5, 64'd0, 64'd5, 1);
        op("div_ovf", F_DIV, 0, 64'h8000_0000_0000_0000, '1,
           64'h8000_0000_0000_0000, 1);
        op("rem_ovf", F_REM, 0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);

        op("mulw", F_MUL, 1, 64'h7FFF_FFFF, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFE, 33);
        op("divw", F_DIV, 1, 64'h1234_5678_8000_0000, '1,
           64'hFFFF_FFFF_8000_0000, 0);
        op("divuw", F_DIVU, 1, 64'hFFFF_FFFF, 64'd2, 64'h7FFF_FFFF, 33);

        // Backpressure then back-to-back accept
        issue(F_DIVU, 0, 64'd100, 64'd7);
        wait_out("bp", 65);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_result", result, 64'd14);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        funct3    = F_REMU;
        word      = 1'b0;
        src1      = 64'd100;
        src2      = 64'd7;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("b2b_in_ready", 64'(in_ready), 64'd1);
        check("b2b_out_drop", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_accept", 64'(busy), 64'd1);
        wait_out("b2b", 65);
        check("b2b", result, 64'd2);
        take();

        // Flush in the middle of CALC
        issue(F_MUL, 0, 64'd11, 64'd13);
        repeat (19) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_busy", 64'(busy), 64'd0);
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_out", 64'(seen), 64'd0);

        // Flush beats a same-cycle request
        @(negedge clk);
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_acc_busy", 64'(busy), 64'd0);
        check("flush_acc_ready", 64'(in_ready), 64'd1);

        // Asynchronous reset mid-CALC
        issue(F_MUL, 0, 64'd7, 64'd9);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_result", result, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        op("post_rst_mul", F_MUL, 0, 64'd2, 64'd3, 64'd6, 65);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
